// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU function codes and PC source selects.
package controle_pkg;

  typedef enum logic [3:0] {
    INICIO, BUSCA, DECOD, EXEC_R, EXEC_I, ESCREG, END_MEM,
    LER_MEM, ESC_MEM, DESVIO, SALTO, PARADO, ERRO
  } estado_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLT  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;
  localparam logic [2:0] OP_HLT  = 3'b111;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;

  localparam logic [1:0] PC_MAIS1  = 2'b00;
  localparam logic [1:0] PC_DESVIO = 2'b01;
  localparam logic [1:0] PC_SALTO  = 2'b10;

  // States that own the shared memory port and are guarded by the wait counter.
  function automatic logic is_mem_state(input estado_t s);
    return (s == BUSCA) || (s == LER_MEM) || (s == ESC_MEM);
  endfunction

  // States whose cycles are accounted in the cycle counter.
  function automatic logic is_active_state(input estado_t s);
    return !((s == INICIO) || (s == PARADO) || (s == ERRO));
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory wait counter shared by the three memory states; flags a timeout on the
// MEM_TIMEOUT-th consecutive cycle without MemPronto.
module contador_espera #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  input  logic mem_pronto_i,
  output logic timeout_o
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !mem_pronto_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // A completion on the last allowed cycle wins over the timeout.
  assign timeout_o = enable_i && !mem_pronto_i && (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback over a
// single shared memory port and counts fetched instructions and active cycles.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           OpCode,
  input  logic                 Zero,
  input  logic                 MemPronto,
  output logic                 MemReq,
  output logic                 IouD,
  output logic                 LerMem,
  output logic                 EscMem,
  output logic                 EscIR,
  output logic                 EscAB,
  output logic                 EscPC,
  output logic [1:0]           PCFonte,
  output logic                 RegDst,
  output logic                 RegFonte,
  output logic                 EscReg,
  output logic                 ULA1,
  output logic                 ULA2,
  output logic                 Beq,
  output logic                 Salto,
  output logic                 Set,
  output logic [2:0]           ULAOp,
  output logic                 Halt,
  output logic                 Erro,
  output logic [CNT_WIDTH-1:0] InstrCont,
  output logic [CNT_WIDTH-1:0] CicloCont,
  output logic [3:0]           estado_o
);

  // Memory handshake: MemReq stays high for the whole memory state; the rising
  // edge that samples MemPronto=1 completes the access and leaves the state.
  // MemPronto seen in any other state is ignored.

  estado_t                estado_q, estado_d;
  logic [2:0]             op_q;
  logic [CNT_WIDTH-1:0]   instr_q, ciclo_q;
  logic                   espera_timeout;

  contador_espera #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_espera (
    .clk_i        (clock),
    .rst_i        (reset),
    .clear_i      (estado_d != estado_q),
    .enable_i     (is_mem_state(estado_q)),
    .mem_pronto_i (MemPronto),
    .timeout_o    (espera_timeout)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIO:  estado_d = BUSCA;
      BUSCA:   if (MemPronto) estado_d = DECOD;
               else if (espera_timeout) estado_d = ERRO;
      DECOD: begin
        case (OpCode)
          OP_ADD, OP_SLT: estado_d = EXEC_R;
          OP_ADDI:        estado_d = EXEC_I;
          OP_LW, OP_SW:   estado_d = END_MEM;
          OP_BEQ:         estado_d = DESVIO;
          OP_J:           estado_d = SALTO;
          default:        estado_d = PARADO;
        endcase
      end
      EXEC_R, EXEC_I: estado_d = ESCREG;
      ESCREG:  estado_d = BUSCA;
      END_MEM: estado_d = (op_q == OP_LW) ? LER_MEM : ESC_MEM;
      LER_MEM: if (MemPronto) estado_d = ESCREG;
               else if (espera_timeout) estado_d = ERRO;
      ESC_MEM: if (MemPronto) estado_d = BUSCA;
               else if (espera_timeout) estado_d = ERRO;
      DESVIO, SALTO: estado_d = BUSCA;
      PARADO:  estado_d = PARADO;
      ERRO:    estado_d = ERRO;
      default: estado_d = INICIO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIO;
      op_q     <= OP_ADD;
      instr_q  <= '0;
      ciclo_q  <= '0;
    end else begin
      estado_q <= estado_d;
      // IR is stable from DECOD on; holding a copy keeps later states self-contained.
      if (estado_q == DECOD) op_q <= OpCode;
      if ((estado_q == BUSCA) && MemPronto) instr_q <= instr_q + CNT_WIDTH'(1);
      if (is_active_state(estado_q)) ciclo_q <= ciclo_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    MemReq   = 1'b0;
    IouD     = 1'b0;
    LerMem   = 1'b0;
    EscMem   = 1'b0;
    EscIR    = 1'b0;
    EscAB    = 1'b0;
    EscPC    = 1'b0;
    PCFonte  = PC_MAIS1;
    RegDst   = 1'b0;
    RegFonte = 1'b0;
    EscReg   = 1'b0;
    ULA1     = 1'b0;
    ULA2     = 1'b0;
    Beq      = 1'b0;
    Salto    = 1'b0;
    Set      = 1'b0;
    ULAOp    = ULA_ADD;
    Halt     = 1'b0;
    Erro     = 1'b0;
    case (estado_q)
      BUSCA: begin
        MemReq = 1'b1;
        LerMem = 1'b1;
        EscIR  = MemPronto;
        EscPC  = MemPronto;
      end
      DECOD:   EscAB = 1'b1;
      EXEC_R:  ULAOp = (op_q == OP_SLT) ? ULA_SUB : ULA_ADD;
      EXEC_I:  ULA2  = 1'b1;
      ESCREG: begin
        EscReg   = 1'b1;
        RegDst   = (op_q == OP_ADDI) || (op_q == OP_LW);
        RegFonte = (op_q == OP_LW);
        Set      = (op_q == OP_SLT);
      end
      END_MEM: ULA2 = 1'b1;
      LER_MEM: begin
        MemReq = 1'b1;
        IouD   = 1'b1;
        LerMem = 1'b1;
      end
      ESC_MEM: begin
        MemReq = 1'b1;
        IouD   = 1'b1;
        EscMem = 1'b1;
      end
      DESVIO: begin
        ULAOp   = ULA_SUB;
        Beq     = 1'b1;
        EscPC   = Zero;
        PCFonte = PC_DESVIO;
      end
      SALTO: begin
        Salto   = 1'b1;
        EscPC   = 1'b1;
        PCFonte = PC_SALTO;
      end
      PARADO:  Halt = 1'b1;
      ERRO:    Erro = 1'b1;
      default: ;
    endcase
  end

  assign InstrCont = instr_q;
  assign CicloCont = ciclo_q;
  assign estado_o  = estado_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-instruction expansion into expected
// per-cycle control words and counter values, checked every cycle.
module tb_controle_multiciclo;

  localparam int MEM_TIMEOUT = 15;
  localparam int W = 54;

  localparam logic [2:0] I_ADD = 3'd0, I_SLT = 3'd1, I_ADDI = 3'd2, I_LW = 3'd3;
  localparam logic [2:0] I_SW = 3'd4, I_BEQ = 3'd5, I_J = 3'd6, I_HLT = 3'd7;

  // Bit positions inside the 22-bit control word.
  localparam int B_MREQ = 21, B_IOUD = 20, B_LER = 19, B_ESC = 18, B_EIR = 17;
  localparam int B_EAB = 16, B_EPC = 15, B_RDST = 12, B_RFON = 11, B_EREG = 10;
  localparam int B_ULA2 = 8, B_BEQ = 7, B_SALTO = 6, B_SET = 5, B_HALT = 1, B_ERRO = 0;

  logic        clock, reset;
  logic [2:0]  OpCode;
  logic        Zero, MemPronto;
  logic        MemReq, IouD, LerMem, EscMem, EscIR, EscAB, EscPC;
  logic [1:0]  PCFonte;
  logic        RegDst, RegFonte, EscReg, ULA1, ULA2, Beq, Salto, Set;
  logic [2:0]  ULAOp;
  logic        Halt, Erro;
  logic [15:0] InstrCont, CicloCont;
  logic [3:0]  estado_o;

  logic [W-1:0] exp_q[$];
  logic [15:0]  ic, cc;
  int           n_tests, n_fail, n_cyc;

  controle_multiciclo #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .OpCode(OpCode), .Zero(Zero), .MemPronto(MemPronto),
    .MemReq(MemReq), .IouD(IouD), .LerMem(LerMem), .EscMem(EscMem), .EscIR(EscIR),
    .EscAB(EscAB), .EscPC(EscPC), .PCFonte(PCFonte), .RegDst(RegDst), .RegFonte(RegFonte),
    .EscReg(EscReg), .ULA1(ULA1), .ULA2(ULA2), .Beq(Beq), .Salto(Salto), .Set(Set),
    .ULAOp(ULAOp), .Halt(Halt), .Erro(Erro), .InstrCont(InstrCont), .CicloCont(CicloCont),
    .estado_o(estado_o)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Control words per cycle type
  function automatic logic [21:0] p_fetch(input logic pr);
    logic [21:0] v = '0;
    v[B_MREQ] = 1'b1; v[B_LER] = 1'b1; v[B_EIR] = pr; v[B_EPC] = pr;
    return v;
  endfunction
  function automatic logic [21:0] p_bit(input int b);
    logic [21:0] v = '0;
    v[b] = 1'b1;
    return v;
  endfunction
  function automatic logic [21:0] p_exr(input logic slt);
    logic [21:0] v = '0;
    v[4:2] = slt ? 3'd1 : 3'd0;
    return v;
  endfunction
  function automatic logic [21:0] p_wb(input logic [2:0] op);
    logic [21:0] v = '0;
    v[B_EREG] = 1'b1;
    v[B_RDST] = (op == I_ADDI) || (op == I_LW);
    v[B_RFON] = (op == I_LW);
    v[B_SET]  = (op == I_SLT);
    return v;
  endfunction
  function automatic logic [21:0] p_mem(input logic [2:0] op);
    logic [21:0] v = '0;
    v[B_MREQ] = 1'b1; v[B_IOUD] = 1'b1;
    if (op == I_LW) v[B_LER] = 1'b1; else v[B_ESC] = 1'b1;
    return v;
  endfunction
  function automatic logic [21:0] p_br(input logic z);
    logic [21:0] v = '0;
    v[4:2] = 3'd1; v[B_BEQ] = 1'b1; v[B_EPC] = z; v[14:13] = 2'b01;
    return v;
  endfunction
  function automatic logic [21:0] p_j();
    logic [21:0] v = '0;
    v[B_SALTO] = 1'b1; v[B_EPC] = 1'b1; v[14:13] = 2'b10;
    return v;
  endfunction

  // Driver tasks
  task automatic cyc(input logic [21:0] c, input logic act, input logic fet);
    exp_q.push_back({c, ic, cc});
    if (act) cc = cc + 16'd1;
    if (fet) ic = ic + 16'd1;
    @(negedge clock);
  endtask

  task automatic rnd_in();
    MemPronto = 1'($urandom_range(0, 1));
    Zero      = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_from(input logic [21:0] c, input logic act);
    reset = 1'b1;
    cyc(c, act, 1'b0);
    ic = '0; cc = '0;
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic instr(input logic [2:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) begin
      MemPronto = 1'b0; Zero = 1'($urandom); OpCode = 3'($urandom);
      cyc(p_fetch(1'b0), 1'b1, 1'b0);
    end
    MemPronto = 1'b1;
    cyc(p_fetch(1'b1), 1'b1, 1'b1);
    OpCode = op; rnd_in();
    cyc(p_bit(B_EAB), 1'b1, 1'b0);
    case (op)
      I_ADD, I_SLT: begin
        rnd_in(); cyc(p_exr(op == I_SLT), 1'b1, 1'b0);
        rnd_in(); cyc(p_wb(op), 1'b1, 1'b0);
      end
      I_ADDI: begin
        rnd_in(); cyc(p_bit(B_ULA2), 1'b1, 1'b0);
        rnd_in(); cyc(p_wb(op), 1'b1, 1'b0);
      end
      I_LW, I_SW: begin
        rnd_in(); cyc(p_bit(B_ULA2), 1'b1, 1'b0);
        for (int i = 0; i < mw && i < MEM_TIMEOUT; i++) begin
          MemPronto = 1'b0; cyc(p_mem(op), 1'b1, 1'b0);
        end
        if (mw < MEM_TIMEOUT) begin
          MemPronto = 1'b1; cyc(p_mem(op), 1'b1, 1'b0);
          if (op == I_LW) begin
            rnd_in(); cyc(p_wb(op), 1'b1, 1'b0);
          end
        end
      end
      I_BEQ: begin
        MemPronto = 1'($urandom_range(0, 1)); Zero = z;
        cyc(p_br(z), 1'b1, 1'b0);
      end
      I_J: begin
        rnd_in(); cyc(p_j(), 1'b1, 1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard
  initial begin
    logic [W-1:0] e;
    logic [21:0]  a;
    forever begin
      @(negedge clock);
      #2;
      n_cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {MemReq, IouD, LerMem, EscMem, EscIR, EscAB, EscPC, PCFonte, RegDst, RegFonte,
             EscReg, ULA1, ULA2, Beq, Salto, Set, ULAOp, Halt, Erro};
        n_tests++;
        if (a !== e[53:32]) begin
          n_fail++;
          $display("FAIL ctl@%0d: got %06h required %06h", n_cyc, a, e[53:32]);
        end
        n_tests++;
        if ({InstrCont, CicloCont} !== e[31:0]) begin
          n_fail++;
          $display("FAIL cnt@%0d: got %0d/%0d required %0d/%0d", n_cyc,
                   InstrCont, CicloCont, e[31:16], e[15:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    n_tests = 0; n_fail = 0; n_cyc = 0; ic = '0; cc = '0;
    reset = 1'b1; OpCode = 3'd0; Zero = 1'b0; MemPronto = 1'b1;
    @(negedge clock);
    #1;
    lit("rst_memreq", 32'(MemReq), 32'd0);
    lit("rst_instrcont", 32'(InstrCont), 32'd0);
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc('0, 1'b0, 1'b0);
    cyc(p_fetch(1'b1), 1'b1, 1'b1);
    OpCode = I_ADDI;
    #1;
    lit("decod_instrcont", 32'(InstrCont), 32'd1);
    lit("decod_escab", 32'(EscAB), 32'd1);
    cyc(p_bit(B_EAB), 1'b1, 1'b0);
    cyc(p_bit(B_ULA2), 1'b1, 1'b0);
    cyc(p_wb(I_ADDI), 1'b1, 1'b0);
    #1;
    lit("addi_next_busca", 32'(MemReq), 32'd1);
    lit("addi_ciclos", 32'(CicloCont), 32'd4);

    instr(I_ADD, 1, 0, 1'b0);
    instr(I_SLT, 0, 0, 1'b0);
    instr(I_LW, 2, 3, 1'b0);
    instr(I_BEQ, 0, 0, 1'b1);
    instr(I_BEQ, 0, 0, 1'b0);
    instr(I_J, 0, 0, 1'b0);
    instr(I_SW, 0, 1, 1'b0);
    instr(I_LW, 0, MEM_TIMEOUT - 1, 1'b0);

    // Reset in the middle of a data read, with MemPronto arriving on that edge.
    MemPronto = 1'b1;
    cyc(p_fetch(1'b1), 1'b1, 1'b1);
    OpCode = I_LW;
    cyc(p_bit(B_EAB), 1'b1, 1'b0);
    cyc(p_bit(B_ULA2), 1'b1, 1'b0);
    MemPronto = 1'b0;
    cyc(p_mem(I_LW), 1'b1, 1'b0);
    cyc(p_mem(I_LW), 1'b1, 1'b0);
    MemPronto = 1'b1;
    reset_from(p_mem(I_LW), 1'b1);
    #1;
    lit("rst_mid_memreq", 32'(MemReq), 32'd0);
    lit("rst_mid_instrcont", 32'(InstrCont), 32'd0);
    cyc('0, 1'b0, 1'b0);

    // Store that never completes.
    instr(I_SW, 0, MEM_TIMEOUT, 1'b0);
    #1;
    lit("timeout_erro", 32'(Erro), 32'd1);
    lit("timeout_memreq", 32'(MemReq), 32'd0);
    lit("timeout_ciclos", 32'(CicloCont), 32'd18);
    for (int i = 0; i < 3; i++) begin
      MemPronto = 1'($urandom_range(0, 1));
      cyc(p_bit(B_ERRO), 1'b0, 1'b0);
    end
    reset_from(p_bit(B_ERRO), 1'b0);
    #1;
    lit("erro_cleared", 32'(Erro), 32'd0);
    cyc('0, 1'b0, 1'b0);

    // Halt as the sixth fetched instruction.
    instr(I_ADD, 0, 0, 1'b0);
    instr(I_ADDI, 1, 0, 1'b0);
    instr(I_BEQ, 0, 0, 1'b1);
    instr(I_J, 0, 0, 1'b0);
    instr(I_SW, 0, 2, 1'b0);
    instr(I_HLT, 0, 0, 1'b0);
    #1;
    lit("halt_flag", 32'(Halt), 32'd1);
    lit("halt_instrcont", 32'(InstrCont), 32'd6);
    for (int i = 0; i < 4; i++) begin
      rnd_in();
      cyc(p_bit(B_HALT), 1'b0, 1'b0);
    end
    lit("halt_frozen", 32'(InstrCont), 32'd6);
    reset_from(p_bit(B_HALT), 1'b0);
    cyc('0, 1'b0, 1'b0);

    #3;
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
